// File: rtl/sbox_layer_seq.sv
// sbox_layer_seq: column-serial Ascon substitution layer driven by an external 5-bit S-box LUT.
// Latency: accept edge, then NCOL SUB cycles; out_valid_o rises NCOL+1 cycles after accept.
// Backpressure: holds the result in DONE until out_ready_i; in_ready_o is low outside IDLE.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid_i/in_ready_o       input state handshake, state_i carries 5 lanes of NCOL bits
//   out_valid_o/out_ready_i     output handshake, state_o shows the working register
//   sbox_addr_o/sbox_data_i     LUT read port, data is combinational from the address
//   busy_o                      high in SUB and DONE so the LUT owner freezes its table
module sbox_layer_seq #(
  parameter int NCOL  = 64,
  parameter int LANES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [LANES*NCOL-1:0] state_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [LANES*NCOL-1:0] state_o,
  output logic [4:0]            sbox_addr_o,
  input  logic [4:0]            sbox_data_i,
  output logic                  busy_o
);

  localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(NCOL - 1);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [LANES*NCOL-1:0] work_q, work_d;

  // Lane views of the working register and the column-substituted version.
  logic [NCOL-1:0]       lane_q   [LANES];
  logic [NCOL-1:0]       lane_sub [LANES];
  logic [LANES*NCOL-1:0] work_sub;
  logic [LANES-1:0]      col_bits;

  // x0 is the address MSB, so lane k lands on bit LANES-1-k of both
  // the address and the returned data.
  always_comb begin
    col_bits = '0;
    work_sub = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_q[k]                = work_q[k*NCOL +: NCOL];
      col_bits[LANES-1-k]      = lane_q[k][col_q];
      lane_sub[k]              = lane_q[k];
      lane_sub[k][col_q]       = sbox_data_i[LANES-1-k];
      work_sub[k*NCOL +: NCOL] = lane_sub[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          work_d  = state_i;
          col_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        work_d = work_sub;
        col_d  = col_q + CW'(1);
        if (col_q == LAST_COL) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode from registered state only.
  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q == SUB) || (state_q == DONE);
  assign sbox_addr_o = (state_q == SUB) ? col_bits : 5'd0;
  assign state_o     = work_q;

endmodule
